// File: rtl/w0rm_core_fetch.sv
// Instruction fetch stage: single outstanding memory request, 2-entry in-order
// decode queue, branch redirect, and pipeline flush with stale-response drain.
module w0rm_core_fetch #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INST_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    PC_STEP      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_valid,
  input  logic                  flush_pipeline,
  input  logic                  next_pc_valid,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_addr_valid,
  input  logic                  inst_mem_ready,
  input  logic                  inst_data_valid,
  input  logic [INST_WIDTH-1:0] inst_data_in,
  output logic                  decode_valid,
  input  logic                  decode_ready,
  output logic [INST_WIDTH-1:0] decode_inst,
  output logic [ADDR_WIDTH-1:0] decode_pc,
  output logic [1:0]            fsm_state
);

  // Handshakes: a transfer happens on any rising edge where valid && ready.
  // valid never depends combinationally on ready, and inst_addr is held while
  // inst_addr_valid waits (only a branch redirect may move it).

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    outstanding;
  logic [ADDR_WIDTH-1:0]   out_pc;
  logic [INST_WIDTH-1:0]   q_inst [2];
  logic [ADDR_WIDTH-1:0]   q_pc   [2];
  logic                    head;
  logic [1:0]              count;

  logic req_fire;
  logic resp;
  logic flush;
  logic redirect;
  logic push;
  logic pop;
  logic tail;

  // A new request waits for the previous response so at most one is in flight.
  assign inst_addr_valid = (state == ST_FETCH) && !outstanding && (count != 2'd2);
  assign inst_addr       = pc;
  assign decode_valid    = (count != 2'd0);
  assign decode_inst     = q_inst[head];
  assign decode_pc       = q_pc[head];
  assign fsm_state       = state;

  assign req_fire = inst_addr_valid && inst_mem_ready;
  assign resp     = inst_data_valid && outstanding;
  assign flush    = branch_valid && flush_pipeline;
  assign redirect = branch_valid && next_pc_valid;
  assign push     = resp && (state == ST_FETCH) && !flush;
  assign pop      = decode_valid && decode_ready && !flush;
  assign tail     = head ^ count[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_VECTOR;
      outstanding <= 1'b0;
      out_pc      <= '0;
      head        <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        // A flush leaves an in-flight request stale unless its answer lands now.
        ST_FETCH: if (flush && (req_fire || (outstanding && !resp))) state <= ST_DRAIN;
        ST_DRAIN: if (resp) state <= ST_FETCH;
        default:  state <= ST_IDLE;
      endcase

      if (req_fire) begin
        outstanding <= 1'b1;
        out_pc      <= pc;
      end else if (resp) begin
        outstanding <= 1'b0;
      end

      if (redirect)      pc <= next_pc & ALIGN_MASK;
      else if (req_fire) pc <= pc + STEP;

      if (flush) begin
        head  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (push) begin
          q_inst[tail] <= inst_data_in;
          q_pc[tail]   <= out_pc;
        end
        if (pop) head <= ~head;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_w0rm_core_fetch.sv
// Bench for w0rm_core_fetch: a transaction-level model of the fetch stream
// checked every cycle, directed scenarios with literal expectations, random traffic.
`timescale 1ns/1ps
module tb_w0rm_core_fetch;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int EW = AW + IW;
  localparam logic [AW-1:0] RV = 32'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          branch_valid = 1'b0;
  logic          flush_pipeline = 1'b0;
  logic          next_pc_valid = 1'b0;
  logic [AW-1:0] next_pc = '0;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_valid;
  logic          inst_mem_ready = 1'b0;
  logic          inst_data_valid = 1'b0;
  logic [IW-1:0] inst_data_in = '0;
  logic          decode_valid;
  logic          decode_ready = 1'b0;
  logic [IW-1:0] decode_inst;
  logic [AW-1:0] decode_pc;
  logic [1:0]    fsm_state;

  w0rm_core_fetch #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_VECTOR(RV), .PC_STEP(2)
  ) dut (
    .clk(clk), .reset(reset),
    .branch_valid(branch_valid), .flush_pipeline(flush_pipeline),
    .next_pc_valid(next_pc_valid), .next_pc(next_pc),
    .inst_addr(inst_addr), .inst_addr_valid(inst_addr_valid),
    .inst_mem_ready(inst_mem_ready),
    .inst_data_valid(inst_data_valid), .inst_data_in(inst_data_in),
    .decode_valid(decode_valid), .decode_ready(decode_ready),
    .decode_inst(decode_inst), .decode_pc(decode_pc),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] h;
    h = a * 32'h9E37_79B1;
    return h[31:16] ^ 16'h5A3C;
  endfunction

  // ---------------- reference model (spec level) ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] pop_log[$];
  logic [AW-1:0] m_pc = RV;
  logic          m_out = 1'b0;
  logic [AW-1:0] m_out_pc = '0;
  int            m_tag = 0;
  int            epoch = 0;
  logic          m_idle = 1'b1;
  logic          acc_flag = 1'b0;
  logic [AW-1:0] acc_addr = '0;

  initial begin : compare_proc
    logic          exp_req, acc, resp, flush, redir;
    logic [EW-1:0] ent;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        m_pc = RV; m_out = 1'b0; m_idle = 1'b1; epoch++;
        acc_flag = 1'b0;
      end else begin
        exp_req = !m_idle && !m_out && (exp_q.size() < 2);
        check("inst_addr_valid", inst_addr_valid, exp_req);
        if (exp_req) check("inst_addr", inst_addr, m_pc);
        check("decode_valid", decode_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          ent = exp_q[0];
          check("decode_pc", decode_pc, ent[EW-1:IW]);
          check("decode_inst", decode_inst, ent[IW-1:0]);
        end
        acc_flag = inst_addr_valid && inst_mem_ready;
        acc_addr = inst_addr;

        acc   = exp_req && inst_mem_ready;
        resp  = inst_data_valid && m_out;
        flush = branch_valid && flush_pipeline;
        redir = branch_valid && next_pc_valid;
        if (exp_q.size() != 0 && decode_ready && !flush) begin
          pop_log.push_back(exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (resp) begin
          if (m_tag == epoch && !flush) exp_q.push_back({m_out_pc, inst_data_in});
          m_out = 1'b0;
        end
        if (acc) begin
          m_out = 1'b1; m_out_pc = m_pc; m_tag = epoch;
        end
        if (flush) begin
          exp_q.delete();
          epoch++;
        end
        if (redir)    m_pc = next_pc & ~32'h1;
        else if (acc) m_pc = m_pc + 32'd2;
        m_idle = 1'b0;
      end
    end
  end

  // ---------------- driver: memory + random stimulus ----------------
  logic          mem_busy = 1'b0;
  int            mem_left = 0;
  logic [AW-1:0] mem_addr = '0;
  int            lat = 1;
  logic          rand_mode = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
    branch_valid = 1'b0; flush_pipeline = 1'b0; next_pc_valid = 1'b0;
    inst_data_valid = 1'b0;
    inst_data_in = IW'($urandom);
    if (acc_flag) begin
      check("one_outstanding", mem_busy, 1'b0);
      if (rand_mode) lat = $urandom_range(1, 4);
      mem_busy = 1'b1; mem_left = lat; mem_addr = acc_addr;
    end
    if (mem_busy) begin
      mem_left--;
      if (mem_left <= 0) begin
        inst_data_valid = 1'b1;
        inst_data_in = mem_word(mem_addr);
        mem_busy = 1'b0;
      end
    end
    if (rand_mode) begin
      inst_mem_ready = ($urandom_range(0, 3) != 0);
      decode_ready   = ($urandom_range(0, 2) != 0);
      reset          = !mem_busy && ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) begin
        branch_valid   = 1'b1;
        flush_pipeline = 1'($urandom_range(0, 1));
        next_pc_valid  = 1'($urandom_range(0, 1));
        next_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                              : AW'($urandom_range(0, 255));
      end
    end
  endtask

  // Leaves the caller in the first cycle after reset deasserts.
  task automatic do_reset();
    for (int k = 0; k < 8 && mem_busy; k++) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int k = 0; k < budget && pop_log.size() < n; k++) tick();
    check("pops_reached", pop_log.size() >= n, 1'b1);
  endtask

  task automatic check_pops(input int base, input string tag);
    logic [EW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      if (pop_log.size() > base + i) begin
        e = pop_log[base + i];
        check({tag, "_pc"}, e[EW-1:IW], AW'(2 * i));
        check({tag, "_inst"}, e[IW-1:0], mem_word(AW'(2 * i)));
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  int            base;
  logic [1:0]    s_drain;
  logic [EW-1:0] last;

  initial begin
    inst_mem_ready = 1'b1; decode_ready = 1'b1; lat = 1;
    tick();
    do_reset();
    check("idle_addr_valid", inst_addr_valid, 1'b0);
    check("idle_decode_valid", decode_valid, 1'b0);
    check("reset_inst_addr", inst_addr, 32'h0);
    check("reset_decode_inst", decode_inst, 16'h0);
    check("reset_decode_pc", decode_pc, 32'h0);
    tick();
    check("first_req_valid", inst_addr_valid, 1'b1);
    check("first_req_addr", inst_addr, 32'h0);
    base = pop_log.size();
    wait_pops(base + 4, 60);
    check_pops(base, "seq");

    // Decode stalled: queue fills to two and requests stop.
    decode_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    check("full_addr_valid", inst_addr_valid, 1'b0);
    check("full_addr", inst_addr, 32'h4);
    check("full_decode_valid", decode_valid, 1'b1);
    check("full_decode_pc", decode_pc, 32'h0);
    base = pop_log.size();
    decode_ready = 1'b1;
    wait_pops(base + 4, 60);
    check_pops(base, "drain");

    // Flush while a latency-3 request is in flight.
    lat = 3;
    do_reset();
    tick();
    tick();
    check("c_accepted", acc_flag, 1'b1);
    branch_valid = 1'b1; flush_pipeline = 1'b1; next_pc_valid = 1'b1; next_pc = 32'h101;
    tick();
    s_drain = fsm_state;
    check("c_drain_valid", inst_addr_valid, 1'b0);
    check("c_drain_decode", decode_valid, 1'b0);
    tick();
    check("c_stale_valid", inst_addr_valid, 1'b0);
    check("c_stale_decode", decode_valid, 1'b0);
    tick();
    check("c_redirect_valid", inst_addr_valid, 1'b1);
    check("c_redirect_addr", inst_addr, 32'h100);
    check("c_state_debug", s_drain != fsm_state, 1'b1);
    for (int k = 0; k < 20 && !decode_valid; k++) tick();
    check("c_decode_seen", decode_valid, 1'b1);
    check("c_decode_pc", decode_pc, 32'h100);
    check("c_decode_inst", decode_inst, mem_word(32'h100));

    // Flush in the same cycle as the response: no drain.
    lat = 1;
    do_reset();
    tick();
    tick();
    check("d_resp_now", inst_data_valid, 1'b1);
    branch_valid = 1'b1; flush_pipeline = 1'b1; next_pc_valid = 1'b1; next_pc = 32'h200;
    tick();
    check("d_next_valid", inst_addr_valid, 1'b1);
    check("d_next_addr", inst_addr, 32'h200);
    check("d_decode_empty", decode_valid, 1'b0);

    // PC wrap at the top of the address space.
    do_reset();
    inst_mem_ready = 1'b0;
    tick();
    branch_valid = 1'b1; flush_pipeline = 1'b1; next_pc_valid = 1'b1; next_pc = 32'hFFFF_FFFF;
    tick();
    check("e_top_valid", inst_addr_valid, 1'b1);
    check("e_top_addr", inst_addr, 32'hFFFF_FFFE);
    inst_mem_ready = 1'b1;
    tick();
    for (int k = 0; k < 10 && !inst_addr_valid; k++) tick();
    check("e_wrap_valid", inst_addr_valid, 1'b1);
    check("e_wrap_addr", inst_addr, 32'h0);
    base = pop_log.size();
    wait_pops(base + 1, 20);
    if (pop_log.size() > base) begin
      last = pop_log[base];
      check("e_top_decode_pc", last[EW-1:IW], 32'hFFFF_FFFE);
    end

    // Reset pulse with a request in flight; its late answer must be ignored.
    lat = 3;
    do_reset();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("f_late_resp", inst_data_valid, 1'b1);
    check("f_idle_valid", inst_addr_valid, 1'b0);
    check("f_idle_decode", decode_valid, 1'b0);
    tick();
    check("f_first_valid", inst_addr_valid, 1'b1);
    check("f_first_addr", inst_addr, RV);
    check("f_decode_empty", decode_valid, 1'b0);
    repeat (10) tick();

    // Random traffic against the model.
    rand_mode = 1'b1;
    repeat (4000) tick();
    rand_mode = 1'b0;
    reset = 1'b0; decode_ready = 1'b1; inst_mem_ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
